// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Captures ID-stage operands and control, applies WB bypass, and inserts bubbles on load-use hazards.
module id_ex_pipeline_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      InValid,
    input  logic [DATA_WIDTH-1:0]     PCPlus4,
    input  logic [DATA_WIDTH-1:0]     ReadData1,
    input  logic [DATA_WIDTH-1:0]     ReadData2,
    input  logic [DATA_WIDTH-1:0]     SignExtImm,
    input  logic [REG_ADDR_WIDTH-1:0] Rs,
    input  logic [REG_ADDR_WIDTH-1:0] Rt,
    input  logic [REG_ADDR_WIDTH-1:0] Rd,
    input  logic                      RegWrite,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      MemToReg,
    input  logic                      RegDst,
    input  logic                      ALUSrc,
    input  logic                      Branch,
    input  logic [ALUOP_WIDTH-1:0]    ALUOp,
    input  logic                      WBRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] WBWriteRegister,
    input  logic [DATA_WIDTH-1:0]     WBWriteData,
    output logic                      LoadUseStall,
    output logic                      ExValid,
    output logic [DATA_WIDTH-1:0]     ExPCPlus4,
    output logic [DATA_WIDTH-1:0]     ExReadData1,
    output logic [DATA_WIDTH-1:0]     ExReadData2,
    output logic [DATA_WIDTH-1:0]     ExImm,
    output logic [REG_ADDR_WIDTH-1:0] ExRs,
    output logic [REG_ADDR_WIDTH-1:0] ExRt,
    output logic [REG_ADDR_WIDTH-1:0] ExRd,
    output logic                      ExRegWrite,
    output logic                      ExMemRead,
    output logic                      ExMemWrite,
    output logic                      ExMemToReg,
    output logic                      ExRegDst,
    output logic                      ExALUSrc,
    output logic                      ExBranch,
    output logic [ALUOP_WIDTH-1:0]    ExALUOp
);

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     read_data1;
        logic [DATA_WIDTH-1:0]     read_data2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
        logic                      mem_to_reg;
        logic                      reg_dst;
        logic                      alu_src;
        logic                      branch;
        logic [ALUOP_WIDTH-1:0]    alu_op;
    } ex_stage_t;

    // An all-zero entry is a bubble: no valid bit, no write-enables, no branch.
    localparam ex_stage_t BUBBLE = '0;

    ex_stage_t ex_q;
    ex_stage_t id_d;
    logic      bypass_rs;
    logic      bypass_rt;
    logic      load_use;

    // The register file is written on the same edge we capture, so WB data must be forwarded here.
    assign bypass_rs = WBRegWrite && (WBWriteRegister == Rs) && (Rs != '0);
    assign bypass_rt = WBRegWrite && (WBWriteRegister == Rt) && (Rt != '0);

    assign load_use = !Reset && ex_q.valid && ex_q.mem_read && InValid &&
                      (ex_q.rt != '0) && ((ex_q.rt == Rs) || (ex_q.rt == Rt));

    // NOTE: combinational blocks assign a full default first so no path can infer a latch.
    always_comb begin
        id_d            = BUBBLE;
        id_d.valid      = 1'b1;
        id_d.pc_plus4   = PCPlus4;
        id_d.read_data1 = bypass_rs ? WBWriteData : ReadData1;
        id_d.read_data2 = bypass_rt ? WBWriteData : ReadData2;
        id_d.imm        = SignExtImm;
        id_d.rs         = Rs;
        id_d.rt         = Rt;
        id_d.rd         = Rd;
        id_d.reg_write  = RegWrite;
        id_d.mem_read   = MemRead;
        id_d.mem_write  = MemWrite;
        id_d.mem_to_reg = MemToReg;
        id_d.reg_dst    = RegDst;
        id_d.alu_src    = ALUSrc;
        id_d.branch     = Branch;
        id_d.alu_op     = ALUOp;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q <= BUBBLE;
        end else if (Flush) begin
            ex_q <= BUBBLE;
        end else if (Stall) begin
            ex_q <= ex_q;
        end else if (load_use || !InValid) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= id_d;
        end
    end

    assign LoadUseStall = load_use;
    assign ExValid      = ex_q.valid;
    assign ExPCPlus4    = ex_q.pc_plus4;
    assign ExReadData1  = ex_q.read_data1;
    assign ExReadData2  = ex_q.read_data2;
    assign ExImm        = ex_q.imm;
    assign ExRs         = ex_q.rs;
    assign ExRt         = ex_q.rt;
    assign ExRd         = ex_q.rd;
    assign ExRegWrite   = ex_q.reg_write;
    assign ExMemRead    = ex_q.mem_read;
    assign ExMemWrite   = ex_q.mem_write;
    assign ExMemToReg   = ex_q.mem_to_reg;
    assign ExRegDst     = ex_q.reg_dst;
    assign ExALUSrc     = ex_q.alu_src;
    assign ExBranch     = ex_q.branch;
    assign ExALUOp      = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the EX-stage contents.
module tb_id_ex_pipeline_register;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [6:0]  ctrl;   // {RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, Branch}
        logic [3:0]  aluop;
    } ex_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [31:0] pc_plus4, read_data1, read_data2, sign_ext_imm;
    logic [4:0]  rs, rt, rd;
    logic [6:0]  in_ctrl;
    logic [3:0]  alu_op;
    logic        wb_reg_write;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;

    logic        load_use_stall, ex_valid;
    logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_dst, ex_alu_src, ex_branch;
    logic [3:0]  ex_alu_op;

    int   total = 0;
    int   bad   = 0;
    ex_t  model = '0;

    id_ex_pipeline_register dut (
        .Clk(clk), .Reset(reset), .Stall(stall), .Flush(flush), .InValid(in_valid),
        .PCPlus4(pc_plus4), .ReadData1(read_data1), .ReadData2(read_data2), .SignExtImm(sign_ext_imm),
        .Rs(rs), .Rt(rt), .Rd(rd),
        .RegWrite(in_ctrl[6]), .MemRead(in_ctrl[5]), .MemWrite(in_ctrl[4]), .MemToReg(in_ctrl[3]),
        .RegDst(in_ctrl[2]), .ALUSrc(in_ctrl[1]), .Branch(in_ctrl[0]), .ALUOp(alu_op),
        .WBRegWrite(wb_reg_write), .WBWriteRegister(wb_write_register), .WBWriteData(wb_write_data),
        .LoadUseStall(load_use_stall), .ExValid(ex_valid),
        .ExPCPlus4(ex_pc_plus4), .ExReadData1(ex_read_data1), .ExReadData2(ex_read_data2), .ExImm(ex_imm),
        .ExRs(ex_rs), .ExRt(ex_rt), .ExRd(ex_rd),
        .ExRegWrite(ex_reg_write), .ExMemRead(ex_mem_read), .ExMemWrite(ex_mem_write),
        .ExMemToReg(ex_mem_to_reg), .ExRegDst(ex_reg_dst), .ExALUSrc(ex_alu_src), .ExBranch(ex_branch),
        .ExALUOp(ex_alu_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hazard rule evaluated on the modelled EX contents and the current ID inputs.
    function automatic logic model_hazard();
        if (reset || !model.valid || !model.ctrl[5] || !in_valid || model.rt == 5'd0) return 1'b0;
        return (model.rt == rs) || (model.rt == rt);
    endfunction

    // What EX should hold after the next edge, from the priority rules.
    function automatic ex_t model_next();
        ex_t n;
        if (reset || flush)                     return '0;
        if (stall)                              return model;
        if (model_hazard() || !in_valid)        return '0;
        n.valid = 1'b1;
        n.pc    = pc_plus4;
        n.rd1   = (wb_reg_write && rs != 0 && wb_write_register == rs) ? wb_write_data : read_data1;
        n.rd2   = (wb_reg_write && rt != 0 && wb_write_register == rt) ? wb_write_data : read_data2;
        n.imm   = sign_ext_imm;
        n.rs    = rs;
        n.rt    = rt;
        n.rd    = rd;
        n.ctrl  = in_ctrl;
        n.aluop = alu_op;
        return n;
    endfunction

    task automatic compare_outputs();
        check("valid", 64'(ex_valid), 64'(model.valid));
        check("pc",    64'(ex_pc_plus4), 64'(model.pc));
        check("rd1",   64'(ex_read_data1), 64'(model.rd1));
        check("rd2",   64'(ex_read_data2), 64'(model.rd2));
        check("imm",   64'(ex_imm), 64'(model.imm));
        check("regs",  64'({ex_rs, ex_rt, ex_rd}), 64'({model.rs, model.rt, model.rd}));
        check("ctrl",  64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_dst,
                            ex_alu_src, ex_branch, ex_alu_op}), 64'({model.ctrl, model.aluop}));
    endtask

    // Check the combinational hazard output, clock once, then check the EX contents.
    task automatic tick();
        ex_t nxt;
        #1;
        check("load_use_stall", 64'(load_use_stall), 64'(model_hazard()));
        nxt = model_next();
        @(posedge clk);
        #1;
        model = nxt;
        compare_outputs();
    endtask

    task automatic randomize_inputs(input bit narrow_regs);
        pc_plus4          = $urandom;
        read_data1        = $urandom;
        read_data2        = $urandom;
        sign_ext_imm      = $urandom;
        rs                = narrow_regs ? 5'($urandom_range(0, 3)) : 5'($urandom);
        rt                = narrow_regs ? 5'($urandom_range(0, 3)) : 5'($urandom);
        rd                = 5'($urandom);
        in_ctrl           = 7'($urandom);
        alu_op            = 4'($urandom);
        wb_reg_write      = 1'($urandom);
        wb_write_register = narrow_regs ? 5'($urandom_range(0, 3)) : 5'($urandom);
        wb_write_data     = $urandom;
        in_valid          = 1'($urandom);
    endtask

    task automatic set_instr(input logic [4:0] s, input logic [4:0] t, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [6:0] c);
        in_valid = 1'b1; rs = s; rt = t; rd = 5'd7;
        read_data1 = d1; read_data2 = d2; in_ctrl = c; alu_op = 4'd2;
        pc_plus4 = 32'h0000_0104; sign_ext_imm = 32'hFFFF_FFF0;
        wb_reg_write = 1'b0; wb_write_register = 5'd0; wb_write_data = 32'h0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        randomize_inputs(1'b0);

        // Reset with random inputs for two edges.
        for (int i = 0; i < 2; i++) begin
            randomize_inputs(1'b0);
            stall = 1'($urandom); flush = 1'($urandom);
            tick();
        end
        check("reset_valid", 64'(ex_valid), 64'd0);
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

        // Normal load.
        set_instr(5'd8, 5'd25, 32'd1, 32'd18, 7'b1000000);
        tick();
        check("norm_rd1", 64'(ex_read_data1), 64'd1);
        check("norm_rd2", 64'(ex_read_data2), 64'd18);
        check("norm_rs",  64'(ex_rs), 64'd8);
        check("norm_rw",  64'(ex_reg_write), 64'd1);

        // WB bypass on Rs, then register 0 is never bypassed.
        set_instr(5'd9, 5'd3, 32'd2, 32'd5, 7'b1000000);
        wb_reg_write = 1'b1; wb_write_register = 5'd9; wb_write_data = 32'hDEAD;
        tick();
        check("byp_rd1", 64'(ex_read_data1), 64'hDEAD);
        set_instr(5'd0, 5'd3, 32'd2, 32'd5, 7'b1000000);
        wb_reg_write = 1'b1; wb_write_register = 5'd0; wb_write_data = 32'hDEAD;
        tick();
        check("byp_r0_rd1", 64'(ex_read_data1), 64'd2);

        // Load-use: lw with Rt=10 in EX, consumer reads Rs=10.
        set_instr(5'd4, 5'd10, 32'd3, 32'd4, 7'b1101010);
        tick();
        set_instr(5'd10, 5'd11, 32'd6, 32'd7, 7'b1000000);
        #1 check("lu_stall", 64'(load_use_stall), 64'd1);
        tick();
        check("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check("lu_bubble_mr",    64'(ex_mem_read), 64'd0);
        // lw targeting $0 never triggers a hazard.
        set_instr(5'd4, 5'd0, 32'd3, 32'd4, 7'b1101010);
        tick();
        set_instr(5'd0, 5'd0, 32'd6, 32'd7, 7'b1000000);
        #1 check("lu_r0_nostall", 64'(load_use_stall), 64'd0);
        tick();

        // Stall for three edges with changing inputs, then Flush overrides Stall.
        set_instr(5'd12, 5'd13, 32'h1234, 32'h5678, 7'b1010001);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(1'b0);
            tick();
        end
        check("stall_rd1", 64'(ex_read_data1), 64'h1234);
        flush = 1'b1;
        tick();
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_mw",    64'(ex_mem_write), 64'd0);
        stall = 1'b0; flush = 1'b0;

        // Reset mid-stream while stalled on valid data.
        set_instr(5'd14, 5'd15, 32'hAAAA, 32'hBBBB, 7'b1111111);
        tick();
        stall = 1'b1; reset = 1'b1;
        tick();
        check("mid_reset_rd1", 64'(ex_read_data1), 64'd0);
        reset = 1'b0; stall = 1'b0;

        // Randomized traffic with a narrow register range to provoke hazards and bypasses.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs(1'b1);
            in_valid = ($urandom_range(0, 9) < 8);
            in_ctrl[5] = ($urandom_range(0, 2) == 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- ID/EX pipeline register of the 5-stage MIPS datapath; sits directly downstream of the register file.
- Captures ReadData1/ReadData2, the decoded immediate, register specifiers and control bits each cycle, and presents them to the EX stage.
- Applies write-back bypass on the register-file read values.
- Detects load-use hazards and inserts bubbles on them; also supports hold (stall) and flush.

Parameters:
DATA_WIDTH, 32, width of data words, PC and immediate
REG_ADDR_WIDTH, 5, register specifier width
ALUOP_WIDTH, 4, ALU operation code width

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Stall  input  1  global hold; registers keep their current contents
Flush  input  1  squash the ID instruction (taken branch or jump); insert bubble
InValid  input  1  ID stage holds a real instruction
PCPlus4  input  DATA_WIDTH  PC+4 of the ID instruction
ReadData1, ReadData2  input  DATA_WIDTH  register-file read ports
SignExtImm  input  DATA_WIDTH  sign-extended immediate
Rs, Rt, Rd  input  REG_ADDR_WIDTH  register specifiers
RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, Branch  input  1 each  decoded control
ALUOp  input  ALUOP_WIDTH  ALU control
WBRegWrite  input  1  write-back stage writes the register file this cycle
WBWriteRegister  input  REG_ADDR_WIDTH  write-back destination
WBWriteData  input  DATA_WIDTH  write-back data
LoadUseStall  output  1  combinational; tells PC and IF/ID to hold
ExValid  output  1  EX holds a real instruction
ExPCPlus4, ExReadData1, ExReadData2, ExImm  output  DATA_WIDTH  registered copies
ExRs, ExRt, ExRd  output  REG_ADDR_WIDTH  registered copies
ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExRegDst, ExALUSrc, ExBranch  output  1 each  registered control
ExALUOp  output  ALUOP_WIDTH  registered ALU control

Behaviour:
- Reset: every Ex* output is 0 (ExValid=0) on the first rising edge with Reset=1.
- LoadUseStall = ExValid & ExMemRead & InValid & (ExRt != 0) & ((ExRt == Rs) | (ExRt == Rt)). Purely combinational; 0 during reset.
- Per-edge priority:
  - Reset: all registers zero.
  - Flush: bubble.
  - Stall: hold all registers.
  - LoadUseStall: bubble.
  - InValid=0: bubble.
  - Otherwise: load the inputs.
- Bubble: ExValid and every Ex* field are 0, so there are no side effects (ExRegWrite=0, ExMemWrite=0, ExBranch=0).
- Bypass on load:
  - ExReadData1 = WBWriteData if WBRegWrite & (WBWriteRegister == Rs) & (Rs != 0); else ReadData1.
  - ExReadData2 follows the same rule using Rt and ReadData2.
  - Rationale: the register-file write and the ID/EX capture occur on the same edge.
- Bypass applies only on a load. Held registers are not refreshed by WB activity during Stall.
- Latency: exactly 1 cycle from inputs to Ex* outputs. No combinational path from any input to any Ex* output.
- Simultaneous Flush and LoadUseStall: Flush wins; a single bubble is inserted. LoadUseStall output still reflects its own equation.
- Stall with a pending load-use condition: the register holds. The hazard persists and bubbles on the first non-stalled edge.
- Reset asserted mid-operation: clears state on that edge regardless of Stall or Flush.
- Register 0 is never bypassed and never triggers LoadUseStall.

Test Plan:
- Reset: Reset=1 for 2 edges with random inputs applied -> all Ex* = 0, LoadUseStall = 0.
- Normal load: InValid=1, Rs=8, Rt=25, ReadData1=1, ReadData2=18, RegWrite=1, ALUOp=2 -> after one edge ExReadData1=1, ExReadData2=18, ExRs=8, ExRegWrite=1, ExValid=1.
- WB bypass: Rs=9, ReadData1=2, WBRegWrite=1, WBWriteRegister=9, WBWriteData=0xDEAD -> ExReadData1=0xDEAD. Repeat with Rs=0 and WBWriteRegister=0 -> ExReadData1 = ReadData1.
- Load-use: EX holds lw with ExRt=10 and ExMemRead=1; ID has Rs=10 -> LoadUseStall=1; next edge ExValid=0 and ExMemRead=0. With ExRt=0 instead -> LoadUseStall=0.
- Stall and flush: Stall=1 for 3 edges with changing inputs -> Ex* unchanged. Flush=1 together with Stall=1 -> bubble (ExValid=0, ExMemWrite=0).
- Reset mid-stream: Reset=1 while Stall=1 and valid data is held -> all Ex* = 0 after one edge.
